// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and sequencing control for the 5-stage pipeline.
// The block detects load-use and HI/LO interlocks. It produces stall and flush
// controls for the PC, IF/ID and ID/EX. It selects EX-stage forwarding from
// MEM or WB, and it tracks the multi-cycle mult/div latency.
//
// Optional build macro HAZ_PERF_CNT_EN adds two free-running 32-bit
// performance counters: stall cycles and flush cycles.
//
// The mult/div tracker is a 4-bit down-counter, not a state machine:
//   counter | meaning
//   0       | idle, HI/LO valid
//   1       | last busy cycle (md_done high)
//   2..15   | mult/div in flight
module pipe_hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_use_rs,
    input  logic       ID_use_rt,
    input  logic       ID_use_hilo,
    input  logic [4:0] EX_rs,
    input  logic [4:0] EX_rt,
    input  logic [4:0] EX_wraddr,
    input  logic       EX_regwrite,
    input  logic       EX_memtoreg,
    input  logic       EX_branch_taken,
    input  logic       EX_md_start,
    input  logic       EX_md_is_div,
    input  logic [4:0] MEM_wraddr,
    input  logic       MEM_regwrite,
    input  logic [4:0] WB_wraddr,
    input  logic       WB_regwrite,
    output logic       stall_pc,
    output logic       stall_ifid,
    output logic       flush_ifid,
    output logic       flush_idex,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       md_busy,
    output logic       md_done
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam logic [3:0] MUL_LAT_4 = 4'(MUL_LAT);
    localparam logic [3:0] DIV_LAT_4 = 4'(DIV_LAT);

    logic [3:0] md_cnt;
    logic [3:0] md_cnt_nxt;
    logic       load_use;
    logic       hilo_stall;
    logic       stall;
    logic       ex_dst_valid;
    logic       mem_dst_valid;
    logic       wb_dst_valid;

    // Hazard detection. A destination of $0 never counts as a producer.
    always_comb begin
        ex_dst_valid  = EX_regwrite  && (EX_wraddr  != 5'd0);
        mem_dst_valid = MEM_regwrite && (MEM_wraddr != 5'd0);
        wb_dst_valid  = WB_regwrite  && (WB_wraddr  != 5'd0);
        load_use      = EX_memtoreg && ex_dst_valid &&
                        ((ID_use_rs && (EX_wraddr == ID_rs)) ||
                         (ID_use_rt && (EX_wraddr == ID_rt)));
        hilo_stall    = ID_use_hilo && md_busy;
        stall         = load_use || hilo_stall;
    end

    // Pipeline control. A taken branch wins: the stalled ID instruction is in
    // the branch shadow and gets squashed anyway.
    always_comb begin
        stall_pc   = 1'b0;
        stall_ifid = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        if (EX_branch_taken) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (stall) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
        end
    end

    // EX operand forwarding. MEM holds the younger result, so it beats WB.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_dst_valid && (MEM_wraddr == EX_rs)) begin
            fwd_a = 2'b10;
        end else if (wb_dst_valid && (WB_wraddr == EX_rs)) begin
            fwd_a = 2'b01;
        end
        if (mem_dst_valid && (MEM_wraddr == EX_rt)) begin
            fwd_b = 2'b10;
        end else if (wb_dst_valid && (WB_wraddr == EX_rt)) begin
            fwd_b = 2'b01;
        end
    end

    // Mult/div latency counter next value. A new start always reloads,
    // including under a taken branch, because EX is older than the shadow.
    always_comb begin
        md_cnt_nxt = md_cnt;
        if (EX_md_start) begin
            md_cnt_nxt = EX_md_is_div ? DIV_LAT_4 : MUL_LAT_4;
        end else if (md_cnt != 4'd0) begin
            md_cnt_nxt = md_cnt - 4'd1;
        end
    end

    // Counter and registered status flags. md_done is set for the cycle in
    // which the counter holds 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_cnt  <= 4'd0;
            md_busy <= 1'b0;
            md_done <= 1'b0;
        end else begin
            md_cnt  <= md_cnt_nxt;
            md_busy <= (md_cnt_nxt != 4'd0);
            md_done <= (md_cnt_nxt == 4'd1);
        end
    end

`ifdef HAZ_PERF_CNT_EN
    // Performance counters. Both wrap naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= 32'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            if (stall_pc) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (flush_ifid) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl. It uses the default parameters
// (MUL_LAT=4, DIV_LAT=12) and covers HAZ_PERF_CNT_EN when that macro is defined.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ID_rs, ID_rt, EX_rs, EX_rt, EX_wraddr, MEM_wraddr, WB_wraddr;
    logic       ID_use_rs, ID_use_rt, ID_use_hilo;
    logic       EX_regwrite, EX_memtoreg, EX_branch_taken, EX_md_start, EX_md_is_div;
    logic       MEM_regwrite, WB_regwrite;
    logic       stall_pc, stall_ifid, flush_ifid, flush_idex, md_busy, md_done;
    logic [1:0] fwd_a, fwd_b;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int busy_cycles;
    int done_pulses;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt),
        .ID_use_hilo(ID_use_hilo),
        .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_wraddr(EX_wraddr), .EX_regwrite(EX_regwrite),
        .EX_memtoreg(EX_memtoreg), .EX_branch_taken(EX_branch_taken),
        .EX_md_start(EX_md_start), .EX_md_is_div(EX_md_is_div),
        .MEM_wraddr(MEM_wraddr), .MEM_regwrite(MEM_regwrite),
        .WB_wraddr(WB_wraddr), .WB_regwrite(WB_regwrite),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .flush_ifid(flush_ifid),
        .flush_idex(flush_idex), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .md_busy(md_busy), .md_done(md_done)
`ifdef HAZ_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        ID_rs = 0; ID_rt = 0; EX_rs = 0; EX_rt = 0; EX_wraddr = 0;
        MEM_wraddr = 0; WB_wraddr = 0;
        ID_use_rs = 0; ID_use_rt = 0; ID_use_hilo = 0;
        EX_regwrite = 0; EX_memtoreg = 0; EX_branch_taken = 0;
        EX_md_start = 0; EX_md_is_div = 0; MEM_regwrite = 0; WB_regwrite = 0;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        #12;
        chk("rst_md_busy", 32'(md_busy), 0);
        chk("rst_md_done", 32'(md_done), 0);
        chk("rst_stall_pc", 32'(stall_pc), 0);
        chk("rst_fwd_a", 32'(fwd_a), 0);
        rst = 1'b0;
        tick();

        // Load-use on rs: one bubble, then the load's result comes from WB.
        EX_memtoreg = 1; EX_regwrite = 1; EX_wraddr = 5; ID_rs = 5; ID_use_rs = 1;
        #1;
        chk("lu_stall_pc", 32'(stall_pc), 1);
        chk("lu_stall_ifid", 32'(stall_ifid), 1);
        chk("lu_flush_idex", 32'(flush_idex), 1);
        chk("lu_flush_ifid", 32'(flush_ifid), 0);
        tick();
        clear_inputs();
        WB_wraddr = 5; WB_regwrite = 1; EX_rs = 5;
        #1;
        chk("lu_next_stall_pc", 32'(stall_pc), 0);
        chk("lu_next_fwd_a", 32'(fwd_a), 32'b01);
        tick();

        // Load-use on rt only counts when rt is actually read.
        clear_inputs();
        EX_memtoreg = 1; EX_regwrite = 1; EX_wraddr = 9; ID_rt = 9; ID_use_rt = 1;
        #1;
        chk("lu_rt_stall", 32'(stall_pc), 1);
        ID_use_rt = 0;
        #1;
        chk("lu_rt_unused", 32'(stall_pc), 0);
        tick();

        // Register $0 is never a hazard or forwarding source.
        clear_inputs();
        EX_memtoreg = 1; EX_regwrite = 1; EX_wraddr = 0; ID_rs = 0; ID_use_rs = 1;
        MEM_wraddr = 0; MEM_regwrite = 1; EX_rs = 0; WB_wraddr = 0; WB_regwrite = 1;
        #1;
        chk("r0_stall_pc", 32'(stall_pc), 0);
        chk("r0_flush_idex", 32'(flush_idex), 0);
        chk("r0_fwd_a", 32'(fwd_a), 0);
        tick();

        // MEM beats WB, then WB wins once MEM stops writing.
        clear_inputs();
        MEM_wraddr = 7; MEM_regwrite = 1; WB_wraddr = 7; WB_regwrite = 1; EX_rt = 7; EX_rs = 3;
        #1;
        chk("prio_fwd_b_mem", 32'(fwd_b), 32'b10);
        chk("prio_fwd_a_none", 32'(fwd_a), 0);
        MEM_regwrite = 0;
        #1;
        chk("prio_fwd_b_wb", 32'(fwd_b), 32'b01);
        EX_rs = 7;
        #1;
        chk("prio_fwd_a_wb", 32'(fwd_a), 32'b01);
        tick();

        // A taken branch overrides a simultaneous load-use stall.
        clear_inputs();
        EX_memtoreg = 1; EX_regwrite = 1; EX_wraddr = 5; ID_rs = 5; ID_use_rs = 1;
        EX_branch_taken = 1;
        #1;
        chk("br_flush_ifid", 32'(flush_ifid), 1);
        chk("br_flush_idex", 32'(flush_idex), 1);
        chk("br_stall_pc", 32'(stall_pc), 0);
        chk("br_stall_ifid", 32'(stall_ifid), 0);
        tick();

        // Div interlock: 12 busy cycles, done in the 12th, released after.
        clear_inputs();
        EX_md_start = 1; EX_md_is_div = 1;
        tick();
        EX_md_start = 0; EX_md_is_div = 0; ID_use_hilo = 1;
        #1;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("div_busy_%0d", i), 32'(md_busy), 1);
            chk($sformatf("div_stall_%0d", i), 32'(stall_pc), 1);
            chk($sformatf("div_done_%0d", i), 32'(md_done), (i == 11) ? 1 : 0);
            tick();
        end
        chk("div_after_busy", 32'(md_busy), 0);
        chk("div_after_stall", 32'(stall_pc), 0);
        chk("div_after_done", 32'(md_done), 0);

        // Reset during busy cycle 5 clears everything at once.
        clear_inputs();
        EX_md_start = 1; EX_md_is_div = 1;
        tick();
        EX_md_start = 0; EX_md_is_div = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_busy_before_rst", 32'(md_busy), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(md_busy), 0);
        chk("mid_rst_done", 32'(md_done), 0);
        #2;
        rst = 1'b0;
        done_pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (md_done) done_pulses++;
        end
        chk("mid_rst_no_done", 32'(done_pulses), 0);

        // Restart: mult, then another mult two cycles later.
        clear_inputs();
        EX_md_start = 1;
        tick();
        EX_md_start = 0;
        busy_cycles = 0; done_pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (md_busy) busy_cycles++;
            if (md_done) done_pulses++;
            EX_md_start = (i == 1);
            tick();
        end
        EX_md_start = 0;
        chk("restart_busy_cycles", 32'(busy_cycles), 6);
        chk("restart_done_pulses", 32'(done_pulses), 1);

        // A start under a taken branch still issues.
        clear_inputs();
        EX_md_start = 1; EX_branch_taken = 1;
        tick();
        clear_inputs();
        chk("start_with_branch_busy", 32'(md_busy), 1);
        for (int i = 0; i < 5; i++) tick();

`ifdef HAZ_PERF_CNT_EN
        rst = 1'b1;
        #2;
        rst = 1'b0;
        chk("perf_rst_stall", perf_stall_cnt, 0);
        chk("perf_rst_flush", perf_flush_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            EX_memtoreg = 1; EX_regwrite = 1; EX_wraddr = 5; ID_rs = 5; ID_use_rs = 1;
            tick();
            clear_inputs();
            tick();
        end
        chk("perf_stall_cnt", perf_stall_cnt, 3);
        EX_branch_taken = 1;
        tick();
        EX_branch_taken = 0;
        chk("perf_flush_cnt", perf_flush_cnt, 1);
        chk("perf_stall_hold", perf_stall_cnt, 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
